// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the transmit encoder, the receive aligner and
// the 8b/10b decoder.
//   SYM_W          : TMDS symbol width in bits
//   PAIRS_PER_SYM  : DDR bit pairs that make up one symbol
//   CTRL_TOKEN_xx  : the four control tokens, bit0 = first bit on the wire
//   state_e        : receive alignment states
package tmds_pkg;

  localparam int unsigned SYM_W         = 10;
  localparam int unsigned PAIRS_PER_SYM = 5;

  localparam logic [SYM_W-1:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH,
    VERIFY,
    LOCKED
  } state_e;

endpackage

// File: rtl/tmds_token_match.sv
// Combinational TMDS control-token detector.
//   win  : candidate 10-bit symbol, bit0 = first bit on the wire
//   hit  : win equals one of the four control tokens
//   ctrl : decoded 2-bit control value, 0 when hit is low
module tmds_token_match
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] win,
  output logic             hit,
  output logic [1:0]       ctrl
);

  always_comb begin
    hit  = 1'b0;
    ctrl = '0;
    case (win)
      CTRL_TOKEN_00: begin hit = 1'b1; ctrl = 2'd0; end
      CTRL_TOKEN_01: begin hit = 1'b1; ctrl = 2'd1; end
      CTRL_TOKEN_10: begin hit = 1'b1; ctrl = 2'd2; end
      CTRL_TOKEN_11: begin hit = 1'b1; ctrl = 2'd3; end
      default: ;
    endcase
  end

endmodule

// File: rtl/tmds_deser_align.sv
// TMDS lane deserializer and symbol aligner. Collects the IDDR bit pairs into
// a 20-bit history, slides a 10-bit window over it once per symbol time and
// hunts for control tokens to find the symbol boundary.
//   clk, rst_n  : half-rate bit clock, asynchronous active-low reset
//   d0, d1      : captured bit pair, d0 earlier in time
//   sym         : aligned symbol, bit0 = first bit on the wire
//   sym_valid   : one-cycle strobe per symbol while locked
//   is_ctrl     : sym is a control token
//   ctrl        : decoded control value (0 when not a token)
//   locked      : alignment locked
//   bit_offset  : window offset 0..9
module tmds_deser_align
  import tmds_pkg::*;
#(
  parameter int unsigned VERIFY_COUNT = 4,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d0,
  input  logic             d1,
  output logic [SYM_W-1:0] sym,
  output logic             sym_valid,
  output logic             is_ctrl,
  output logic [1:0]       ctrl,
  output logic             locked,
  output logic [3:0]       bit_offset
);

  localparam int unsigned VW = $clog2(VERIFY_COUNT + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [VW-1:0] VCNT_MAX   = VW'(VERIFY_COUNT);
  localparam logic [TW-1:0] TCNT_MAX   = TW'(LOCK_TIMEOUT);
  localparam logic [2:0]    PHASE_LAST = 3'(PAIRS_PER_SYM - 1);

  logic [19:0]      sr_q;
  logic [2:0]       phase_q;
  state_e           state_q, state_d;
  logic [3:0]       off_q, off_d, off_inc;
  logic [VW-1:0]    vcnt_q, vcnt_d, vcnt_inc;
  logic [TW-1:0]    tcnt_q, tcnt_d, tcnt_inc;
  logic [SYM_W-1:0] sym_q;
  logic             sym_valid_q, is_ctrl_q;
  logic [1:0]       ctrl_q;

  logic             strobe;
  logic [SYM_W-1:0] win;
  logic             hit;
  logic [1:0]       tok_ctrl;

  assign strobe = (phase_q == PHASE_LAST);
  // Window is taken from the registered history, before this cycle's shift.
  assign win    = SYM_W'(sr_q >> off_q);

  tmds_token_match u_match (
    .win  (win),
    .hit  (hit),
    .ctrl (tok_ctrl)
  );

  always_comb begin
    state_d  = state_q;
    off_d    = off_q;
    vcnt_d   = vcnt_q;
    tcnt_d   = tcnt_q;
    off_inc  = (off_q == 4'd9) ? '0 : off_q + 4'd1;
    vcnt_inc = (vcnt_q == VCNT_MAX) ? vcnt_q : vcnt_q + 1'b1;
    tcnt_inc = (tcnt_q == TCNT_MAX) ? tcnt_q : tcnt_q + 1'b1;
    if (strobe) begin
      case (state_q)
        SEARCH: begin
          if (hit) begin
            state_d = VERIFY;
            vcnt_d  = VW'(1);
          end else begin
            off_d = off_inc;
          end
        end
        VERIFY: begin
          if (hit) begin
            vcnt_d = vcnt_inc;
            if (vcnt_inc == VCNT_MAX) begin
              state_d = LOCKED;
              tcnt_d  = '0;
            end
          end else begin
            state_d = SEARCH;
            vcnt_d  = '0;
            off_d   = off_inc;
          end
        end
        LOCKED: begin
          if (hit) begin
            tcnt_d = '0;
          end else begin
            tcnt_d = tcnt_inc;
            if (tcnt_inc == TCNT_MAX) state_d = SEARCH;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q    <= '0;
      phase_q <= '0;
      state_q <= SEARCH;
      off_q   <= '0;
      vcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      sr_q    <= {d1, d0, sr_q[19:2]};
      phase_q <= strobe ? '0 : phase_q + 3'd1;
      state_q <= state_d;
      off_q   <= off_d;
      vcnt_q  <= vcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // Symbols are published only for strobes that find the FSM already locked;
  // the strobe that completes verification produces no output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      is_ctrl_q   <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      sym_valid_q <= strobe && (state_q == LOCKED);
      if (strobe && (state_q == LOCKED)) begin
        sym_q     <= win;
        is_ctrl_q <= hit;
        ctrl_q    <= tok_ctrl;
      end
    end
  end

  assign sym        = sym_q;
  assign sym_valid  = sym_valid_q;
  assign is_ctrl    = is_ctrl_q;
  assign ctrl       = ctrl_q;
  assign locked     = (state_q == LOCKED);
  assign bit_offset = off_q;

endmodule

// File: tb/tb_tmds_deser_align.sv
module tb_tmds_deser_align;

  localparam int VC = 4;
  localparam int TO = 16;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] DAT = 10'h1F0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       d0 = 1'b0;
  logic       d1 = 1'b0;
  logic [9:0] sym;
  logic       sym_valid;
  logic       is_ctrl;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] bit_offset;

  always #5 clk = ~clk;

  tmds_deser_align #(
    .VERIFY_COUNT (VC),
    .LOCK_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .d0         (d0),
    .d1         (d1),
    .sym        (sym),
    .sym_valid  (sym_valid),
    .is_ctrl    (is_ctrl),
    .ctrl       (ctrl),
    .locked     (locked),
    .bit_offset (bit_offset)
  );

  typedef struct {
    logic [9:0] sym;
    logic       is_ctrl;
    logic [1:0] ctrl;
  } exp_t;

  typedef struct {
    int         pad;
    logic [9:0] tok;
    int         nsym;
    logic [3:0] exp_off;
    logic       exp_lock;
    logic [1:0] exp_ctrl;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // reference model of the aligner, working on the raw received bit history
  bit   hist[$];
  bit   tx[$];
  exp_t sb[$];
  int   m_state, m_off, m_vcnt, m_tcnt, m_phase;
  bit   m_valid;

  // observations of the DUT for the hand-written sequences
  exp_t got[$];
  int   offs[$];
  int   offc[$];
  int   cyc, lock_rise, drop_off, prev_off;
  logic prev_locked;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sym"}, 32'(sym), 0);
    chk({tag, "_sym_valid"}, 32'(sym_valid), 0);
    chk({tag, "_is_ctrl"}, 32'(is_ctrl), 0);
    chk({tag, "_ctrl"}, 32'(ctrl), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_bit_offset"}, 32'(bit_offset), 0);
  endtask

  task automatic model_strobe;
    logic [9:0] w;
    bit         h;
    logic [1:0] c;
    int         base;
    base = hist.size() - 20 + m_off;
    for (int j = 0; j < 10; j++) w[j] = (base + j >= 0) ? hist[base + j] : 1'b0;
    h = 1'b1;
    c = 2'd0;
    if (w == T00) c = 2'd0;
    else if (w == T01) c = 2'd1;
    else if (w == T10) c = 2'd2;
    else if (w == T11) c = 2'd3;
    else h = 1'b0;
    if (m_state == 2) begin
      sb.push_back('{w, h, c});
      m_valid = 1'b1;
    end
    case (m_state)
      0: if (h) begin m_state = 1; m_vcnt = 1; end
         else m_off = (m_off + 1) % 10;
      1: if (h) begin
           m_vcnt++;
           if (m_vcnt == VC) begin m_state = 2; m_tcnt = 0; end
         end else begin
           m_state = 0; m_vcnt = 0; m_off = (m_off + 1) % 10;
         end
      default: if (h) m_tcnt = 0;
               else begin
                 m_tcnt++;
                 if (m_tcnt == TO) m_state = 0;
               end
    endcase
  endtask

  // Called on a falling edge: model the coming rising edge, drive the pair,
  // then compare on the next falling edge.
  task automatic step(input bit b0, input bit b1);
    exp_t e;
    m_valid = 1'b0;
    if (m_phase == 4) model_strobe();
    m_phase = (m_phase == 4) ? 0 : m_phase + 1;
    hist.push_back(b0);
    hist.push_back(b1);
    d0 = b0;
    d1 = b1;
    @(negedge clk);
    cyc++;
    chk("locked", 32'(locked), 32'(m_state == 2));
    chk("bit_offset", 32'(bit_offset), 32'(m_off));
    chk("sym_valid", 32'(sym_valid), 32'(m_valid));
    if (m_valid && sb.size() > 0) begin
      e = sb.pop_front();
      chk("sym", 32'(sym), 32'(e.sym));
      chk("is_ctrl", 32'(is_ctrl), 32'(e.is_ctrl));
      chk("ctrl", 32'(ctrl), 32'(e.ctrl));
    end
    if (sym_valid) got.push_back('{sym, is_ctrl, ctrl});
    if (prev_locked && !locked) drop_off = bit_offset;
    if (locked && !prev_locked && lock_rise < 0) lock_rise = cyc;
    if (int'(bit_offset) != prev_off) begin
      offs.push_back(bit_offset);
      offc.push_back(cyc);
    end
    prev_locked = locked;
    prev_off    = bit_offset;
  endtask

  task automatic push_pad(input int n);
    for (int i = 0; i < n; i++) tx.push_back(1'b0);
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int j = 0; j < 10; j++) tx.push_back(s[j]);
  endtask

  task automatic run_pairs(input int n);
    bit a, b;
    for (int i = 0; i < n && tx.size() >= 2; i++) begin
      a = tx.pop_front();
      b = tx.pop_front();
      step(a, b);
    end
  endtask

  task automatic run_tx;
    run_pairs(tx.size() / 2);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    d0 = 1'b0;
    d1 = 1'b0;
    hist.delete(); tx.delete(); sb.delete();
    got.delete(); offs.delete(); offc.delete();
    m_state = 0; m_off = 0; m_vcnt = 0; m_tcnt = 0; m_phase = 0; m_valid = 1'b0;
    cyc = 0; lock_rise = -1; drop_off = -1; prev_off = 0; prev_locked = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    vec_t tbl[5];
    int   i0, run, ndat;

    // wire-level offset of the token stream vs. the offset the search lands on
    tbl[0] = '{pad: 0, tok: T00, nsym: 20, exp_off: 4'd2, exp_lock: 1'b1, exp_ctrl: 2'd0};
    tbl[1] = '{pad: 3, tok: T00, nsym: 20, exp_off: 4'd5, exp_lock: 1'b1, exp_ctrl: 2'd0};
    tbl[2] = '{pad: 0, tok: T01, nsym: 20, exp_off: 4'd2, exp_lock: 1'b1, exp_ctrl: 2'd1};
    tbl[3] = '{pad: 7, tok: T10, nsym: 20, exp_off: 4'd9, exp_lock: 1'b1, exp_ctrl: 2'd2};
    tbl[4] = '{pad: 8, tok: T11, nsym: 20, exp_off: 4'd0, exp_lock: 1'b1, exp_ctrl: 2'd3};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      push_pad(tbl[v].pad);
      for (int k = 0; k < tbl[v].nsym; k++) push_sym(tbl[v].tok);
      run_tx();
      chk("tbl_offset", 32'(bit_offset), 32'(tbl[v].exp_off));
      chk("tbl_locked", 32'(locked), 32'(tbl[v].exp_lock));
      if (got.size() > 0) begin
        chk("tbl_last_is_ctrl", 32'(got[got.size()-1].is_ctrl), 1);
        chk("tbl_last_ctrl", 32'(got[got.size()-1].ctrl), 32'(tbl[v].exp_ctrl));
        chk("tbl_last_sym", 32'(got[got.size()-1].sym), 32'(tbl[v].tok));
      end else begin
        n_vec++; n_err++;
        $display("FAIL tbl_pulses: got 0 sym_valid pulses expected >0 (entry %0d)", v);
      end
    end

    // first lock: four aligned tokens end at the 30th edge after reset
    do_reset();
    repeat (12) push_sym(T00);
    run_tx();
    chk("lock_cycle", 32'(lock_rise), 30);

    // data symbols then a different token while locked
    got.delete();
    repeat (8) push_sym(DAT);
    repeat (2) push_sym(T11);
    run_tx();
    i0 = -1;
    for (int i = 0; i < got.size(); i++) if (i0 < 0 && got[i].is_ctrl == 1'b0) i0 = i;
    run = 0;
    if (i0 >= 0)
      while (i0 + run < got.size() && got[i0+run].is_ctrl == 1'b0 && got[i0+run].sym == DAT) run++;
    chk("data_run", 32'(run), 8);
    if (i0 >= 0 && i0 + 8 < got.size())
      chk("ctrl_after_data", {29'd0, got[i0+8].is_ctrl, got[i0+8].ctrl}, 32'b111);
    else begin
      n_vec++; n_err++;
      $display("FAIL ctrl_after_data: got no pulse expected is_ctrl=1 ctrl=3");
    end
    chk("data_still_locked", 32'(locked), 1);

    // timeout: 16 non-token symbols drop lock, offset unchanged at the drop
    do_reset();
    repeat (12) push_sym(T00);
    run_tx();
    got.delete();
    repeat (18) push_sym(DAT);
    run_tx();
    ndat = 0;
    foreach (got[i]) if (got[i].is_ctrl == 1'b0) ndat++;
    chk("timeout_pulses", 32'(ndat), 16);
    chk("timeout_drop_off", 32'(drop_off), 2);
    chk("timeout_locked", 32'(locked), 0);

    // verification broken by a data symbol on the third window
    do_reset();
    repeat (3) push_sym(T00);
    repeat (3) push_sym(DAT);
    run_tx();
    chk("brk_pulses", 32'(got.size()), 0);
    chk("brk_locked", 32'(locked), 0);
    if (offs.size() >= 3) begin
      chk("brk_off0", 32'(offs[0]), 1);
      chk("brk_off1", 32'(offs[1]), 2);
      chk("brk_off2", 32'(offs[2]), 3);
      chk("brk_hold", 32'(offc[2] - offc[1]), 15);
    end else begin
      n_vec++; n_err++;
      $display("FAIL brk_offsets: got %0d offset changes expected >=3", offs.size());
    end

    // asynchronous reset in the middle of a symbol while locked
    do_reset();
    repeat (13) push_sym(T00);
    run_pairs(62);
    chk("pre_rst_locked", 32'(locked), 1);
    #2 rst_n = 1'b0;
    #1 check_zero("async");
    @(negedge clk);
    do_reset();
    repeat (8) push_sym(T00);
    run_tx();
    chk("relock_cycle", 32'(lock_rise), 30);
    chk("relock_locked", 32'(locked), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
